// File: rtl/vga_pkg.sv
// VGA timing package: default 640x480@60 constants and position type.
// Shared by the sync generator and pixel consumers (paddle, ball, mixer).
package vga_pkg;

   localparam int POS_W = 12;

   typedef logic [POS_W-1:0] pos_t;

   localparam int VGA_H_VISIBLE = 640;
   localparam int VGA_H_FRONT   = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BACK    = 48;
   localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT
                                + VGA_H_SYNC + VGA_H_BACK;

   localparam int VGA_V_VISIBLE = 480;
   localparam int VGA_V_FRONT   = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BACK    = 33;
   localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT
                                + VGA_V_SYNC + VGA_V_BACK;

   localparam logic VGA_SYNC_POL = 1'b0;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle from the sync generator to pixel consumers.
// master drives the beam position and strobes, slave observes them.
interface vga_sync_gen_if;
   import vga_pkg::*;

   pos_t h_pos;
   pos_t v_pos;
   logic hsync;
   logic vsync;
   logic video_on;
   logic pix_tick;
   logic frame_tick;

   modport master (
      output h_pos, v_pos, hsync, vsync,
      output video_on, pix_tick, frame_tick
   );

   modport slave (
      input h_pos, v_pos, hsync, vsync,
      input video_on, pix_tick, frame_tick
   );

endinterface

// File: rtl/vga_axis_cnt.sv
// One VGA axis: wrapping position counter with registered sync decode.
// vis_nxt exposes the visible flag of the upcoming position for the top.
module vga_axis_cnt
   import vga_pkg::*;
#(
   parameter int   VISIBLE  = VGA_H_VISIBLE,
   parameter int   FRONT    = VGA_H_FRONT,
   parameter int   SYNC     = VGA_H_SYNC,
   parameter int   BACK     = VGA_H_BACK,
   parameter logic SYNC_POL = VGA_SYNC_POL
) (
   input  logic in_clk,
   input  logic reset,
   input  logic en,
   output pos_t pos,
   output logic wrap,
   output logic sync,
   output logic vis_nxt
);

   localparam int   TOTAL  = VISIBLE + FRONT + SYNC + BACK;
   localparam pos_t LAST   = pos_t'(TOTAL - 1);
   localparam pos_t VIS_HI = pos_t'(VISIBLE);
   localparam pos_t SYN_LO = pos_t'(VISIBLE + FRONT);
   localparam pos_t SYN_HI = pos_t'(VISIBLE + FRONT + SYNC);

   pos_t nxt;
   logic in_win;

   assign wrap = (pos == LAST);

   always_comb begin
      nxt = pos;
      if (en)
         nxt = wrap ? '0 : pos + 1'b1;
   end

   // decode from nxt so sync lands in the same cycle as its position
   assign in_win  = (nxt >= SYN_LO) && (nxt < SYN_HI);
   assign vis_nxt = (nxt < VIS_HI);

   always_ff @(posedge in_clk) begin
      if (reset) begin
         pos  <= '0;
         sync <= ~SYNC_POL;
      end else begin
         pos  <= nxt;
         sync <= in_win ? SYNC_POL : ~SYNC_POL;
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator; define VGA_PIXEL_DIV2_EN to run pixels at in_clk/2.
// All outputs registered and aligned with the position they describe.
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int   H_VISIBLE = VGA_H_VISIBLE,
   parameter int   H_FRONT   = VGA_H_FRONT,
   parameter int   H_SYNC    = VGA_H_SYNC,
   parameter int   H_BACK    = VGA_H_BACK,
   parameter int   V_VISIBLE = VGA_V_VISIBLE,
   parameter int   V_FRONT   = VGA_V_FRONT,
   parameter int   V_SYNC    = VGA_V_SYNC,
   parameter int   V_BACK    = VGA_V_BACK,
   parameter logic SYNC_POL  = VGA_SYNC_POL
) (
   input  logic           in_clk,
   input  logic           reset,
   vga_sync_gen_if.master vga
);

   pos_t h_pos;
   pos_t v_pos;
   logic h_wrap;
   logic v_wrap;
   logic h_vis;
   logic v_vis;
   logic hsync;
   logic vsync;
   logic pix_tick;
   logic run;
   logic video_on;
   logic frame_tick;

`ifdef VGA_PIXEL_DIV2_EN
   logic phase;

   // the release cycle holds (0,0); advance on every second cycle
   always_ff @(posedge in_clk) begin
      if (reset) begin
         phase    <= 1'b0;
         pix_tick <= 1'b0;
      end else begin
         phase    <= ~phase;
         pix_tick <= phase;
      end
   end
`else
   always_ff @(posedge in_clk) begin
      if (reset)
         pix_tick <= 1'b0;
      else
         pix_tick <= 1'b1;
   end
`endif

   vga_axis_cnt #(
      .VISIBLE (H_VISIBLE),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK),
      .SYNC_POL(SYNC_POL)
   ) u_h (
      .in_clk (in_clk),
      .reset  (reset),
      .en     (pix_tick),
      .pos    (h_pos),
      .wrap   (h_wrap),
      .sync   (hsync),
      .vis_nxt(h_vis)
   );

   vga_axis_cnt #(
      .VISIBLE (V_VISIBLE),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK),
      .SYNC_POL(SYNC_POL)
   ) u_v (
      .in_clk (in_clk),
      .reset  (reset),
      .en     (pix_tick & h_wrap),
      .pos    (v_pos),
      .wrap   (v_wrap),
      .sync   (vsync),
      .vis_nxt(v_vis)
   );

   // run marks the release edge so (0,0) after reset still ticks the frame
   always_ff @(posedge in_clk) begin
      if (reset) begin
         run        <= 1'b0;
         video_on   <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         run        <= 1'b1;
         video_on   <= h_vis & v_vis;
         frame_tick <= ~run | (pix_tick & h_wrap & v_wrap);
      end
   end

   assign vga.h_pos      = h_pos;
   assign vga.v_pos      = v_pos;
   assign vga.hsync      = hsync;
   assign vga.vsync      = vsync;
   assign vga.video_on   = video_on;
   assign vga.pix_tick   = pix_tick;
   assign vga.frame_tick = frame_tick;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench: default-timing DUT plus a tiny-timing SYNC_POL=1 DUT,
// each checked cycle by cycle against an independent timing model.
module tb_vga_sync_gen;
   import vga_pkg::*;

`ifdef VGA_PIXEL_DIV2_EN
   localparam int DIV = 2;
`else
   localparam int DIV = 1;
`endif

   localparam int BHV = 8, BHF = 2, BHS = 3, BHB = 2;
   localparam int BVV = 4, BVF = 1, BVS = 2, BVB = 1;
   localparam int B_FRAME = (BHV+BHF+BHS+BHB) * (BVV+BVF+BVS+BVB);

   typedef struct packed {
      logic [11:0] h;
      logic [11:0] v;
      logic        hs;
      logic        vs;
      logic        vid;
      logic        pix;
      logic        ft;
   } obs_t;

   typedef struct packed {
      obs_t a;
      obs_t b;
   } pair_t;

   logic clk;
   logic rst_a;
   logic rst_b;
   int   na;
   int   nb;
   int   n_chk;
   int   n_fail;
   int   b_prev;
   int   b_vcnt;
   pair_t q[$];

   vga_sync_gen_if if_a();
   vga_sync_gen_if if_b();

   vga_sync_gen dut_a (
      .in_clk(clk),
      .reset (rst_a),
      .vga   (if_a)
   );

   vga_sync_gen #(
      .H_VISIBLE(BHV), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
      .V_VISIBLE(BVV), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB),
      .SYNC_POL (1'b1)
   ) dut_b (
      .in_clk(clk),
      .reset (rst_b),
      .vga   (if_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t model(
      input int n,
      input int hv, input int hf, input int hs, input int hb,
      input int vv, input int vf, input int vs, input int vb,
      input logic pol
   );
      obs_t o;
      int p, ht, vt, h, v;
      o = '0;
      o.hs = ~pol;
      o.vs = ~pol;
      if (n >= 0) begin
         ht = hv + hf + hs + hb;
         vt = vv + vf + vs + vb;
         p  = n / DIV;
         h  = p % ht;
         v  = (p / ht) % vt;
         o.h   = 12'(h);
         o.v   = 12'(v);
         o.hs  = (h >= hv+hf && h < hv+hf+hs) ? pol : ~pol;
         o.vs  = (v >= vv+vf && v < vv+vf+vs) ? pol : ~pol;
         o.vid = (h < hv) && (v < vv);
         o.pix = ((n % DIV) == DIV - 1);
         o.ft  = ((n % DIV) == 0) && h == 0 && v == 0;
      end
      return o;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cmp(input string p, input obs_t g, input obs_t e);
      chk({p, "_h_pos"},      32'(g.h), 32'(e.h));
      chk({p, "_v_pos"},      32'(g.v), 32'(e.v));
      chk({p, "_hsync"},      32'(g.hs), 32'(e.hs));
      chk({p, "_vsync"},      32'(g.vs), 32'(e.vs));
      chk({p, "_video_on"},   32'(g.vid), 32'(e.vid));
      chk({p, "_pix_tick"},   32'(g.pix), 32'(e.pix));
      chk({p, "_frame_tick"}, 32'(g.ft), 32'(e.ft));
   endtask

   task automatic step(input logic ra, input logic rb);
      pair_t e;
      obs_t  ga, gb;
      rst_a = ra;
      rst_b = rb;
      @(posedge clk);
      na = ra ? -1 : na + 1;
      nb = rb ? -1 : nb + 1;
      e.a = model(na, VGA_H_VISIBLE, VGA_H_FRONT, VGA_H_SYNC,
                  VGA_H_BACK, VGA_V_VISIBLE, VGA_V_FRONT,
                  VGA_V_SYNC, VGA_V_BACK, 1'b0);
      e.b = model(nb, BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB, 1'b1);
      q.push_back(e);
      @(negedge clk);
      e  = q.pop_front();
      ga = '{if_a.h_pos, if_a.v_pos, if_a.hsync, if_a.vsync,
             if_a.video_on, if_a.pix_tick, if_a.frame_tick};
      gb = '{if_b.h_pos, if_b.v_pos, if_b.hsync, if_b.vsync,
             if_b.video_on, if_b.pix_tick, if_b.frame_tick};
      cmp("a", ga, e.a);
      cmp("b", gb, e.b);
      if (na == 0)
         chk("a_rel_ft_vid", 32'({ga.ft, ga.vid}), 32'd3);
      if (na == 656*DIV - 1)
         chk("a_hs_655", 32'(ga.hs), 32'd1);
      if (na == 656*DIV)
         chk("a_hs_fall", 32'(ga.hs), 32'd0);
      if (na == 752*DIV)
         chk("a_hs_rise", 32'(ga.hs), 32'd1);
      if (na == 799*DIV)
         chk("a_h_799", 32'(ga.h), 32'd799);
      if (na == 800*DIV)
         chk("a_wrap_hv", 32'({ga.h, ga.v}), 32'({12'd0, 12'd1}));
      if (na == 639*DIV)
         chk("a_vid_639", 32'(ga.vid), 32'd1);
      if (na == 640*DIV)
         chk("a_vid_640", 32'(ga.vid), 32'd0);
      if (nb < 0) begin
         b_prev = -1;
         b_vcnt = 0;
      end else begin
         if (gb.ft) begin
            if (b_prev >= 0) begin
               chk("b_frame_period", 32'(nb - b_prev), 32'(B_FRAME*DIV));
               chk("b_video_count", 32'(b_vcnt), 32'(BHV*BVV*DIV));
            end
            b_prev = nb;
            b_vcnt = 0;
         end
         if (gb.vid)
            b_vcnt++;
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      na     = -1;
      nb     = -1;
      b_prev = -1;
      b_vcnt = 0;
      rst_a  = 1'b1;
      rst_b  = 1'b1;
      repeat (3) step(1'b1, 1'b1);
      for (int i = 0; i < 2400*DIV; i++)
         step(na == (2*800 + 700)*DIV,
              nb == (3*B_FRAME + 5*15 + 11)*DIV);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
